// File: rtl/ulpi_pck_scheduler_if.sv
// FIFO read sides and framed byte stream of the ULPI receive-path scheduler.
interface ulpi_pck_scheduler_if;
    logic        info_empty;
    logic        info_rd_en;
    logic [15:0] info_data;
    logic        data_empty;
    logic        data_rd_en;
    logic [7:0]  data_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    // Scheduler side: sole reader of both FIFOs, source of the framed stream.
    modport master (
        input  info_empty, info_data, data_empty, data_data, out_ready,
        output info_rd_en, data_rd_en, out_data, out_valid
    );

    // Environment side: the two FIFOs and the downstream serial transmitter.
    modport slave (
        output info_empty, info_data, data_empty, data_data, out_ready,
        input  info_rd_en, data_rd_en, out_data, out_valid
    );
endinterface

// File: rtl/ulpi_pck_scheduler.sv
// Drains the packet-info and data FIFOs and emits one framed byte stream per
// packet: sync, info hi, info lo, payload, trailer (OK or timeout ERR).
module ulpi_pck_scheduler #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [7:0]  TRAIL_OK  = 8'h5A,
    parameter logic [7:0]  TRAIL_ERR = 8'hEE,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    ulpi_pck_scheduler_if.master  bus,
    output logic                  busy,
    output logic                  err_timeout,
    output logic [15:0]           pck_count
);
    localparam int unsigned CNT_W = 10;
    localparam int unsigned TMO_W = 16;
    localparam int unsigned PCK_W = 16;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        INFO_WAIT,
        HDR0,
        HDR1,
        HDR2,
        DATA_RD,
        DATA_WAIT,
        DATA_OUT,
        TRAIL
    } state_t;

    state_t             state, state_n;
    logic [15:0]        info_r, info_n;
    logic [CNT_W-1:0]   remaining, remaining_n;
    logic [TMO_W-1:0]   tmo_cnt, tmo_n;
    logic               err_flag, err_flag_n;
    logic [7:0]         out_data_r, out_data_n;
    logic               out_valid_r, out_valid_n;
    logic               err_timeout_n;
    logic [PCK_W-1:0]   pck_count_n;
    logic               busy_n;
    logic               info_rd_en_c, data_rd_en_c;
    logic               xfer_c;

    // A byte leaves when the registered valid meets downstream ready.
    assign xfer_c = out_valid_r && bus.out_ready;

    // Read strobes are issued in the same cycle the empty flag is seen low,
    // so read data lands exactly one cycle later in the *_WAIT states.
    assign bus.info_rd_en = info_rd_en_c && rst;
    assign bus.data_rd_en = data_rd_en_c && rst;
    assign bus.out_data   = out_data_r;
    assign bus.out_valid  = out_valid_r;

    // Next-state and next-register values for the framing sequence.
    always_comb begin
        state_n       = state;
        info_n        = info_r;
        remaining_n   = remaining;
        tmo_n         = tmo_cnt;
        err_flag_n    = err_flag;
        out_data_n    = out_data_r;
        out_valid_n   = out_valid_r;
        err_timeout_n = err_timeout;
        pck_count_n   = pck_count;
        info_rd_en_c  = 1'b0;
        data_rd_en_c  = 1'b0;

        case (state)
            IDLE: begin
                if (en && !bus.info_empty) begin
                    info_rd_en_c = 1'b1;
                    state_n      = INFO_WAIT;
                end
            end
            INFO_WAIT: begin
                info_n      = bus.info_data;
                remaining_n = bus.info_data[CNT_W-1:0];
                out_data_n  = SYNC_BYTE;
                out_valid_n = 1'b1;
                state_n     = HDR0;
            end
            HDR0: begin
                if (xfer_c) begin
                    out_data_n = info_r[15:8];
                    state_n    = HDR1;
                end
            end
            HDR1: begin
                if (xfer_c) begin
                    out_data_n = info_r[7:0];
                    state_n    = HDR2;
                end
            end
            HDR2: begin
                if (xfer_c) begin
                    if (remaining == '0) begin
                        out_data_n = err_flag ? TRAIL_ERR : TRAIL_OK;
                        state_n    = TRAIL;
                    end else begin
                        out_valid_n = 1'b0;
                        state_n     = DATA_RD;
                    end
                end
            end
            DATA_RD: begin
                if (!bus.data_empty) begin
                    data_rd_en_c = 1'b1;
                    tmo_n        = '0;
                    state_n      = DATA_WAIT;
                end else if (tmo_cnt == TMO_LAST) begin
                    // Abort: owed bytes stay in the FIFO, host resyncs on sync byte.
                    tmo_n         = '0;
                    err_flag_n    = 1'b1;
                    err_timeout_n = 1'b1;
                    out_data_n    = TRAIL_ERR;
                    out_valid_n   = 1'b1;
                    state_n       = TRAIL;
                end else begin
                    tmo_n = tmo_cnt + TMO_W'(1);
                end
            end
            DATA_WAIT: begin
                out_data_n  = bus.data_data;
                out_valid_n = 1'b1;
                state_n     = DATA_OUT;
            end
            DATA_OUT: begin
                if (xfer_c) begin
                    remaining_n = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        out_data_n = err_flag ? TRAIL_ERR : TRAIL_OK;
                        state_n    = TRAIL;
                    end else begin
                        out_valid_n = 1'b0;
                        state_n     = DATA_RD;
                    end
                end
            end
            TRAIL: begin
                if (xfer_c) begin
                    pck_count_n = pck_count + PCK_W'(1);
                    err_flag_n  = 1'b0;
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                out_valid_n = 1'b0;
                state_n     = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            info_r      <= '0;
            remaining   <= '0;
            tmo_cnt     <= '0;
            err_flag    <= 1'b0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            err_timeout <= 1'b0;
            pck_count   <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            info_r      <= info_n;
            remaining   <= remaining_n;
            tmo_cnt     <= tmo_n;
            err_flag    <= err_flag_n;
            out_data_r  <= out_data_n;
            out_valid_r <= out_valid_n;
            err_timeout <= err_timeout_n;
            pck_count   <= pck_count_n;
            busy        <= busy_n;
        end
    end
endmodule
